// File: rtl/gat_pkg.sv
// Shared widths, packed record layouts and FSM encoding for the WH sparse-matrix engine.
// Defaults describe the production configuration; width helpers also serve reduced builds.
package gat_pkg;

  localparam int DATA_WIDTH      = 8;
  localparam int WH_DATA_WIDTH   = 12;
  localparam int TOTAL_NODES     = 13264;
  localparam int NUM_FEATURE_IN  = 1433;
  localparam int NUM_FEATURE_OUT = 16;
  localparam int MAX_NODES       = 168;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int col_idx_w(input int nfi);
    return width_of(nfi);
  endfunction

  // row_len counts non-zeros in a row, so it must be able to hold NUM_FEATURE_IN itself
  function automatic int row_len_w(input int nfi);
    return width_of(nfi + 1);
  endfunction

  localparam int COL_IDX_W       = col_idx_w(NUM_FEATURE_IN);
  localparam int ROW_LEN_W       = row_len_w(NUM_FEATURE_IN);
  localparam int NUM_NODE_W      = width_of(MAX_NODES);
  localparam int NODE_INFO_WIDTH = ROW_LEN_W + NUM_NODE_W + 1;
  localparam int WH_WIDTH        = NUM_FEATURE_OUT * WH_DATA_WIDTH + NUM_NODE_W + 1;

  typedef struct packed {
    logic [ROW_LEN_W-1:0]  row_len;
    logic [NUM_NODE_W-1:0] num_node;
    logic                  flag;
  } node_info_t;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] value;
    logic [COL_IDX_W-1:0]         col_idx;
  } h_elem_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INFO  = 3'd1;
  localparam logic [2:0] S_ACCUM = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_INFO  = S_INFO,
    ST_ACCUM = S_ACCUM,
    ST_WRITE = S_WRITE,
    ST_DONE  = S_DONE
  } wh_state_e;

endpackage

// File: rtl/wh_spmm_engine_if.sv
// Stream bundle of the WH engine: node_info in, CSR H elements in, WH rows out.
// master = upstream producer / WH sink side, slave = the engine.
interface wh_spmm_engine_if #(
  parameter int INFO_W = 12,
  parameter int H_W    = 19,
  parameter int ADDR_W = 14,
  parameter int WH_W   = 201
);
  logic              info_vld_i;
  logic              info_rdy_o;
  logic [INFO_W-1:0] info_i;
  logic              h_vld_i;
  logic              h_rdy_o;
  logic [H_W-1:0]    h_i;
  logic              wh_vld_o;
  logic              wh_rdy_i;
  logic [ADDR_W-1:0] wh_addr_o;
  logic [WH_W-1:0]   wh_o;

  modport master (
    output info_vld_i, info_i, h_vld_i, h_i, wh_rdy_i,
    input  info_rdy_o, h_rdy_o, wh_vld_o, wh_addr_o, wh_o
  );

  modport slave (
    input  info_vld_i, info_i, h_vld_i, h_i, wh_rdy_i,
    output info_rdy_o, h_rdy_o, wh_vld_o, wh_addr_o, wh_o
  );
endinterface

// File: rtl/wh_mac_lane.sv
// One WH output column: signed multiply-accumulate with clear/enable.
// WH_SAT_EN defined: saturating accumulate; otherwise wraps modulo 2^WH_DATA_WIDTH.
module wh_mac_lane #(
  parameter int DATA_WIDTH    = 8,
  parameter int WH_DATA_WIDTH = 12
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic                            en,
  input  logic signed [DATA_WIDTH-1:0]    h_val,
  input  logic signed [DATA_WIDTH-1:0]    w_val,
  output logic signed [WH_DATA_WIDTH-1:0] acc
);
  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]            prod;
  logic signed [WH_DATA_WIDTH-1:0] nxt;

  assign prod = h_val * w_val;

`ifdef WH_SAT_EN
  // Sum is widened past both operands so the clamp sees the true value
  localparam int SW = ((PW > WH_DATA_WIDTH) ? PW : WH_DATA_WIDTH) + 1;
  localparam logic signed [SW-1:0] MAXV = SW'((2 ** (WH_DATA_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = SW'(-(2 ** (WH_DATA_WIDTH - 1)));

  logic signed [SW-1:0] sum;
  assign sum = SW'(acc) + SW'(prod);

  always_comb begin
    nxt = sum[WH_DATA_WIDTH-1:0];
    if (sum > MAXV)      nxt = MAXV[WH_DATA_WIDTH-1:0];
    else if (sum < MINV) nxt = MINV[WH_DATA_WIDTH-1:0];
  end
`else
  assign nxt = acc + WH_DATA_WIDTH'(prod);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= nxt;
  end
endmodule

// File: rtl/wh_spmm_engine.sv
// Sparse H (CSR) x dense W engine: one WH row per node_info record, written in row order.
// Optional WH_SAT_EN selects saturating accumulation inside each wh_mac_lane.
module wh_spmm_engine #(
  parameter int DATA_WIDTH      = gat_pkg::DATA_WIDTH,
  parameter int WH_DATA_WIDTH   = gat_pkg::WH_DATA_WIDTH,
  parameter int TOTAL_NODES     = gat_pkg::TOTAL_NODES,
  parameter int NUM_FEATURE_IN  = gat_pkg::NUM_FEATURE_IN,
  parameter int NUM_FEATURE_OUT = gat_pkg::NUM_FEATURE_OUT,
  parameter int MAX_NODES       = gat_pkg::MAX_NODES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic w_rdy_i,
  input  logic [NUM_FEATURE_OUT-1:0][NUM_FEATURE_IN-1:0][DATA_WIDTH-1:0] wgt_i,
  wh_spmm_engine_if.slave bus,
  output logic done_o
);
  import gat_pkg::*;

  localparam int COL_W  = col_idx_w(NUM_FEATURE_IN);
  localparam int RL_W   = row_len_w(NUM_FEATURE_IN);
  localparam int NN_W   = width_of(MAX_NODES);
  localparam int ADDR_W = width_of(TOTAL_NODES);

  typedef struct packed {
    logic [RL_W-1:0] row_len;
    logic [NN_W-1:0] num_node;
    logic            flag;
  } info_t;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] value;
    logic [COL_W-1:0]             col_idx;
  } helem_t;

  wh_state_e       state;
  info_t           info_f, info_q;
  helem_t          h_f;
  logic [RL_W-1:0] elem_cnt;
  logic [ADDR_W-1:0] row_cnt;
  logic            info_xfer, h_xfer, wh_xfer, col_ok;
  logic [NUM_FEATURE_OUT*WH_DATA_WIDTH-1:0] acc_flat;

  assign info_f = bus.info_i;
  assign h_f    = bus.h_i;

  assign bus.info_rdy_o = (state == ST_INFO);
  assign bus.h_rdy_o    = (state == ST_ACCUM);
  assign bus.wh_vld_o   = (state == ST_WRITE);
  assign done_o         = (state == ST_DONE);

  assign info_xfer = bus.info_vld_i & bus.info_rdy_o;
  assign h_xfer    = bus.h_vld_i & bus.h_rdy_o;
  assign wh_xfer   = bus.wh_vld_o & bus.wh_rdy_i;
  assign col_ok    = int'(h_f.col_idx) < NUM_FEATURE_IN;

  assign bus.wh_addr_o = row_cnt;
  assign bus.wh_o      = {acc_flat, info_q.num_node, info_q.flag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      info_q   <= '0;
      elem_cnt <= '0;
      row_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (w_rdy_i) state <= ST_INFO;
        ST_INFO: if (info_xfer) begin
          info_q   <= info_f;
          elem_cnt <= '0;
          state    <= (info_f.row_len == '0) ? ST_WRITE : ST_ACCUM;
        end
        ST_ACCUM: if (h_xfer) begin
          elem_cnt <= elem_cnt + RL_W'(1);
          if (elem_cnt == info_q.row_len - RL_W'(1)) state <= ST_WRITE;
        end
        ST_WRITE: if (wh_xfer) begin
          row_cnt <= row_cnt + ADDR_W'(1);
          state   <= (row_cnt == ADDR_W'(TOTAL_NODES - 1)) ? ST_DONE : ST_INFO;
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar j = 0; j < NUM_FEATURE_OUT; j++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] w_sel;
    // Out-of-range column contributes a zero product but still counts as an element
    assign w_sel = col_ok ? wgt_i[j][h_f.col_idx] : '0;

    wh_mac_lane #(
      .DATA_WIDTH   (DATA_WIDTH),
      .WH_DATA_WIDTH(WH_DATA_WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (info_xfer),
      .en   (h_xfer),
      .h_val(h_f.value),
      .w_val(w_sel),
      .acc  (acc_flat[j*WH_DATA_WIDTH +: WH_DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_wh_spmm_engine.sv
// Bench for wh_spmm_engine: directed vector table on a 4x2 single-row build,
// randomized multi-row runs on a 5x3 three-row build checked against a reference model.
module tb_wh_spmm_engine;
  import gat_pkg::*;

  localparam int DW   = 8;
  localparam int WHW  = 12;
  localparam int MAXN = 168;
  localparam int NN_W = width_of(MAXN);

  localparam int A_NFI = 4, A_NFO = 2, A_TN = 1;
  localparam int A_COL_W  = col_idx_w(A_NFI);
  localparam int A_INFO_W = row_len_w(A_NFI) + NN_W + 1;
  localparam int A_H_W    = DW + A_COL_W;
  localparam int A_ADDR_W = width_of(A_TN);
  localparam int A_WH_W   = A_NFO * WHW + NN_W + 1;

  localparam int B_NFI = 5, B_NFO = 3, B_TN = 3;
  localparam int B_COL_W  = col_idx_w(B_NFI);
  localparam int B_INFO_W = row_len_w(B_NFI) + NN_W + 1;
  localparam int B_H_W    = DW + B_COL_W;
  localparam int B_ADDR_W = width_of(B_TN);
  localparam int B_WH_W   = B_NFO * WHW + NN_W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic w_rdy_a, w_rdy_b, done_a, done_b;
  logic [A_NFO-1:0][A_NFI-1:0][DW-1:0] wgt_a;
  logic [B_NFO-1:0][B_NFI-1:0][DW-1:0] wgt_b;

  wh_spmm_engine_if #(.INFO_W(A_INFO_W), .H_W(A_H_W), .ADDR_W(A_ADDR_W), .WH_W(A_WH_W)) ifa ();
  wh_spmm_engine_if #(.INFO_W(B_INFO_W), .H_W(B_H_W), .ADDR_W(B_ADDR_W), .WH_W(B_WH_W)) ifb ();

  wh_spmm_engine #(
    .DATA_WIDTH(DW), .WH_DATA_WIDTH(WHW), .TOTAL_NODES(A_TN),
    .NUM_FEATURE_IN(A_NFI), .NUM_FEATURE_OUT(A_NFO), .MAX_NODES(MAXN)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .w_rdy_i(w_rdy_a), .wgt_i(wgt_a), .bus(ifa), .done_o(done_a)
  );

  wh_spmm_engine #(
    .DATA_WIDTH(DW), .WH_DATA_WIDTH(WHW), .TOTAL_NODES(B_TN),
    .NUM_FEATURE_IN(B_NFI), .NUM_FEATURE_OUT(B_NFO), .MAX_NODES(MAXN)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .w_rdy_i(w_rdy_b), .wgt_i(wgt_b), .bus(ifb), .done_o(done_b)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int row_len;
    int num_node;
    int flag;
    int val[4];
    int col[4];
    int exp0;
    int exp1;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: got no handshake expected one within the cycle budget", nm);
  endtask

  function automatic logic [63:0] z12(input int v);
    return 64'(v & 32'hFFF);
  endfunction

  // Reference accumulate rule: wrap or clamp to the WH element range
  function automatic int upd(input int acc, input int p);
    int s;
`ifdef WH_SAT_EN
    s = acc + p;
    if (s > (2 ** (WHW - 1)) - 1) s = (2 ** (WHW - 1)) - 1;
    if (s < -(2 ** (WHW - 1)))    s = -(2 ** (WHW - 1));
`else
    s = (acc + p) % (2 ** WHW);
    if (s < 0) s += 2 ** WHW;
    if (s >= 2 ** (WHW - 1)) s -= 2 ** WHW;
`endif
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    w_rdy_a = 1'b0; w_rdy_b = 1'b0;
    ifa.info_vld_i = 1'b0; ifa.h_vld_i = 1'b0; ifa.wh_rdy_i = 1'b0;
    ifa.info_i = '0; ifa.h_i = '0;
    ifb.info_vld_i = 1'b0; ifb.h_vld_i = 1'b0; ifb.wh_rdy_i = 1'b0;
    ifb.info_i = '0; ifb.h_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_w1();
    int c0[4];
    int c1[4];
    c0 = '{1, 2, 3, 4};
    c1 = '{-1, 0, 0, 5};
    for (int k = 0; k < A_NFI; k++) begin
      wgt_a[0][k] = 8'(c0[k]);
      wgt_a[1][k] = 8'(c1[k]);
    end
  endtask

  task automatic a_info(input int rl, input int nn, input int fl);
    int n = 0;
    ifa.info_i = A_INFO_W'((rl << (NN_W + 1)) | (nn << 1) | fl);
    ifa.info_vld_i = 1'b1;
    while (!ifa.info_rdy_o && n < 20) begin tick(); n++; end
    if (n >= 20) timeout("a_info_wait");
    tick();
    ifa.info_vld_i = 1'b0;
  endtask

  task automatic a_h(input int v, input int c);
    int n = 0;
    ifa.h_i = A_H_W'(((v & 255) << A_COL_W) | c);
    ifa.h_vld_i = 1'b1;
    while (!ifa.h_rdy_o && n < 20) begin tick(); n++; end
    if (n >= 20) timeout("a_h_wait");
    tick();
    ifa.h_vld_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [63:0] e;
    int cnt;
    do_reset();
    set_w1();
    w_rdy_a = 1'b1;
    a_info(v.row_len, v.num_node, v.flag);
    w_rdy_a = 1'b0;
    if (v.row_len == 0) check({tag, "_zero_row_vld"}, 64'(ifa.wh_vld_o), 64'(1));
    for (int k = 0; k < v.row_len; k++) begin
      a_h(v.val[k], v.col[k]);
      if (k == v.row_len - 1) check({tag, "_last_h_vld"}, 64'(ifa.wh_vld_o), 64'(1));
    end
    e = (z12(v.exp1) << (WHW + NN_W + 1)) | (z12(v.exp0) << (NN_W + 1))
      | 64'((v.num_node << 1) | v.flag);
    ifa.wh_rdy_i = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      check({tag, "_stall_wh"}, 64'(ifa.wh_o), e);
      check({tag, "_stall_addr"}, 64'(ifa.wh_addr_o), 64'(0));
      check({tag, "_stall_ctl"}, {61'b0, ifa.wh_vld_o, ifa.h_rdy_o, ifa.info_rdy_o}, 64'(4));
    end
    ifa.wh_rdy_i = 1'b1;
    cnt = 0;
    for (int s = 0; s < 4; s++) begin
      if (ifa.wh_vld_o && ifa.wh_rdy_i) cnt++;
      tick();
      if (s == 0) check({tag, "_done"}, 64'(done_a), 64'(1));
    end
    check({tag, "_xfer_count"}, 64'(cnt), 64'(1));
    ifa.wh_rdy_i = 1'b0;
  endtask

  task automatic b_info(input int rl, input int nn, input int fl);
    int n = 0;
    ifb.info_i = B_INFO_W'((rl << (NN_W + 1)) | (nn << 1) | fl);
    ifb.info_vld_i = 1'b1;
    while (!ifb.info_rdy_o && n < 20) begin tick(); n++; end
    if (n >= 20) timeout("b_info_wait");
    tick();
    ifb.info_vld_i = 1'b0;
  endtask

  task automatic b_h(input int v, input int c);
    int n = 0;
    ifb.h_i = B_H_W'(((v & 255) << B_COL_W) | c);
    ifb.h_vld_i = 1'b1;
    while (!ifb.h_rdy_o && n < 20) begin tick(); n++; end
    if (n >= 20) timeout("b_h_wait");
    tick();
    ifb.h_vld_i = 1'b0;
  endtask

  initial begin
    int wm[B_NFO][B_NFI];
    int acc[B_NFO];
    int bv[4];
    int bc[4];
    int rl, nn, fl, p, n;
    bit got;
    logic [63:0] e;

    vecs[0] = '{row_len: 2, num_node: 5, flag: 0, val: '{3, -2, 0, 0}, col: '{1, 3, 0, 0},
                exp0: -2, exp1: -10};
    vecs[1] = '{row_len: 0, num_node: 7, flag: 1, val: '{0, 0, 0, 0}, col: '{0, 0, 0, 0},
                exp0: 0, exp1: 0};
    vecs[2] = '{row_len: 4, num_node: 167, flag: 1, val: '{1, 1, 1, 1}, col: '{0, 1, 2, 3},
                exp0: 10, exp1: 4};
    vecs[3] = '{row_len: 3, num_node: 0, flag: 0, val: '{-128, -128, -128, 0},
                col: '{0, 0, 0, 0}, exp0: -384, exp1: 384};
    wgt_a = '0;
    wgt_b = '0;

    // Reset state and IDLE gating on w_rdy_i
    do_reset();
    check("rst_a_ctl", {60'b0, ifa.info_rdy_o, ifa.h_rdy_o, ifa.wh_vld_o, done_a}, 64'(0));
    check("rst_a_wh", 64'(ifa.wh_o), 64'(0));
    check("rst_a_addr", 64'(ifa.wh_addr_o), 64'(0));
    check("rst_b_ctl", {60'b0, ifb.info_rdy_o, ifb.h_rdy_o, ifb.wh_vld_o, done_b}, 64'(0));
    check("rst_b_wh", 64'(ifb.wh_o), 64'(0));
    repeat (3) tick();
    check("idle_hold", 64'(ifa.info_rdy_o), 64'(0));
    w_rdy_a = 1'b1;
    tick();
    check("idle_to_info", 64'(ifa.info_rdy_o), 64'(1));

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Three 127*127 products into lane 0
    do_reset();
    wgt_a = '0;
    wgt_a[0][0] = 8'd127;
    w_rdy_a = 1'b1;
    a_info(3, 1, 0);
    for (int k = 0; k < 3; k++) a_h(127, 0);
    check("acc_wrap_sat", 64'(ifa.wh_o[NN_W + 1 +: WHW]),
          z12(upd(upd(upd(0, 127 * 127), 127 * 127), 127 * 127)));
    check("acc_wrap_lane1", 64'(ifa.wh_o[NN_W + 1 + WHW +: WHW]), 64'(0));

    // Asynchronous reset in the middle of a row, then rerun from row 0
    do_reset();
    set_w1();
    w_rdy_a = 1'b1;
    a_info(2, 5, 0);
    a_h(3, 1);
    check("mid_accum_rdy", 64'(ifa.h_rdy_o), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ctl", {60'b0, ifa.info_rdy_o, ifa.h_rdy_o, ifa.wh_vld_o, done_a}, 64'(0));
    check("async_rst_wh", 64'(ifa.wh_o), 64'(0));
    run_vec(vecs[0], "rerun");

    // Randomized multi-row runs with stalls
    for (int run = 0; run < 12; run++) begin
      do_reset();
      for (int j = 0; j < B_NFO; j++)
        for (int c = 0; c < B_NFI; c++) begin
          wgt_b[j][c] = 8'($urandom);
          wm[j][c] = int'($signed(wgt_b[j][c]));
        end
      w_rdy_b = 1'b1;
      for (int r = 0; r < B_TN; r++) begin
        rl = int'($urandom_range(0, 4));
        nn = int'($urandom_range(0, MAXN - 1));
        fl = int'($urandom_range(0, 1));
        for (int k = 0; k < 4; k++) begin
          bv[k] = int'($urandom_range(0, 255)) - 128;
          bc[k] = int'($urandom_range(0, 7));
        end
        for (int j = 0; j < B_NFO; j++) begin
          acc[j] = 0;
          for (int k = 0; k < rl; k++) begin
            p = (bc[k] < B_NFI) ? bv[k] * wm[j][bc[k]] : 0;
            acc[j] = upd(acc[j], p);
          end
        end
        e = 64'((nn << 1) | fl);
        for (int j = 0; j < B_NFO; j++) e = e | (z12(acc[j]) << (NN_W + 1 + j * WHW));

        repeat ($urandom_range(0, 2)) tick();
        b_info(rl, nn, fl);
        for (int k = 0; k < rl; k++) begin
          repeat ($urandom_range(0, 2)) tick();
          b_h(bv[k], bc[k]);
        end
        got = 1'b0;
        n = 0;
        while (!got && n < 60) begin
          ifb.wh_rdy_i = 1'($urandom_range(0, 1));
          #1;
          if (ifb.wh_vld_o && ifb.wh_rdy_i) begin
            check($sformatf("rand%0d_row%0d_wh", run, r), 64'(ifb.wh_o), e);
            check($sformatf("rand%0d_row%0d_addr", run, r), 64'(ifb.wh_addr_o), 64'(r));
            got = 1'b1;
          end
          tick();
          n++;
        end
        ifb.wh_rdy_i = 1'b0;
        if (!got) timeout("rand_wh_wait");
        check($sformatf("rand%0d_row%0d_done", run, r), 64'(done_b), 64'(r == B_TN - 1));
      end
      check($sformatf("rand%0d_done_rdy", run), {62'b0, ifb.info_rdy_o, ifb.h_rdy_o}, 64'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
